// File: rtl/cyclic_decoder_systematic.sv
// cyclic_decoder_systematic: serial (15,11) cyclic Hamming decoder, g(x)=x^4+x+1, single-error correction
module cyclic_decoder_systematic #(
    parameter int N = 15,
    parameter int K = 11,
    parameter logic [3:0] POLY = 4'b0011
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_bit,
    output logic       in_ready,
    output logic       out_valid,
    output logic       out_bit,
    input  logic       out_ready,
    output logic       out_last,
    output logic       out_err,
    output logic [3:0] out_err_pos
);
    typedef enum logic [1:0] {RECV, DECODE, SEND} state_t;

    // Entry j holds x^j mod g(x), the syndrome of a lone error at degree j.
    function automatic logic [4*N-1:0] build_tbl();
        logic [4*N-1:0] t;
        logic [3:0] r;
        t = '0;
        r = 4'b0001;
        for (int j = 0; j < N; j++) begin
            t[4*j +: 4] = r;
            r = {r[2:0], 1'b0} ^ (r[3] ? POLY : 4'b0);
        end
        return t;
    endfunction

    localparam logic [4*N-1:0] TBL = build_tbl();

    state_t         r_state;
    logic [N-1:0]   r_buf;
    logic [3:0]     r_syn;
    logic [3:0]     r_cnt;
    logic [3:0]     r_idx;
    logic           r_in_ready;
    logic           r_out_valid;
    logic           r_out_last;
    logic           r_out_err;
    logic [3:0]     r_out_pos;
    logic [3:0]     w_pos;
    logic [3:0]     w_syn_nxt;
    logic [N-1:0]   w_flip;

    always_comb begin
        w_pos = '0;
        for (int j = 0; j < N; j++)
            w_pos = (TBL[4*j +: 4] == r_syn) ? 4'(j) : w_pos;
    end

    assign w_syn_nxt = {r_syn[2:0], in_bit} ^ (r_syn[3] ? POLY : 4'b0);
    assign w_flip    = (r_syn != 4'b0) ? ({{(N-1){1'b0}}, 1'b1} << w_pos) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RECV;
            r_buf       <= '0;
            r_syn       <= '0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_err   <= 1'b0;
            r_out_pos   <= '0;
        end else begin
            case (r_state)
                RECV: if (in_valid && r_in_ready) begin
                    r_buf <= {r_buf[N-2:0], in_bit};
                    r_syn <= w_syn_nxt;
                    r_cnt <= (r_cnt == 4'(N-1)) ? 4'b0 : r_cnt + 4'd1;
                    if (r_cnt == 4'(N-1)) begin
                        r_state    <= DECODE;
                        r_in_ready <= 1'b0;
                    end
                end
                DECODE: begin
                    r_buf       <= r_buf ^ w_flip;
                    r_out_err   <= r_syn != 4'b0;
                    r_out_pos   <= (r_syn != 4'b0) ? w_pos : 4'b0;
                    r_idx       <= '0;
                    r_out_valid <= 1'b1;
                    r_out_last  <= 1'b0;
                    r_state     <= SEND;
                end
                SEND: if (out_ready) begin
                    // The buffer shifts toward the MSB so out_bit is always r_buf[N-1].
                    r_buf <= r_buf << 1;
                    if (r_idx == 4'(K-1)) begin
                        r_idx       <= '0;
                        r_syn       <= '0;
                        r_cnt       <= '0;
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= RECV;
                    end else begin
                        r_idx      <= r_idx + 4'd1;
                        r_out_last <= r_idx == 4'(K-2);
                    end
                end
                default: r_state <= RECV;
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_bit     = r_buf[N-1];
    assign out_last    = r_out_last;
    assign out_err     = r_out_err;
    assign out_err_pos = r_out_pos;
endmodule
